multdiv_step_counter: RTL and testbench
=======================================

Name: multdiv_step_counter

Overview:
- Parametrised iteration counter for the multiply/divide datapath sequencer.
- Counts datapath steps from 0 to a terminal value, then stops or wraps; exposes busy, last-step and done flags.
- Adds start/clear control, a stall input, and a configurable width, terminal count and wrap mode.
- Instantiated once per multdiv unit, between the operation decoder and the shift/add datapath.

Parameters:
- WIDTH, 5, width of the count register; elaboration error if WIDTH < 1.
- MAX_COUNT, 31, terminal count (iterations minus 1); elaboration error unless 1 <= MAX_COUNT <= 2**WIDTH-1.
- WRAP, 0, 0 = stop after the terminal step; 1 = wrap to 0 and keep running.

Ports:
- clock  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; highest priority below reset.
- start  in  1  begin a count sequence; sampled in IDLE only.
- stall  in  1  hold the count for this cycle while running.
- count  out  WIDTH  current step index, registered.
- busy  out  1  high while in RUN.
- last  out  1  combinational: RUN and count == MAX_COUNT.
- done  out  1  registered one-cycle pulse after the terminal step is taken.

Behaviour:
- States (2-bit): IDLE=0, RUN=1. Codes 2,3 are illegal and recover to IDLE on the next edge, with count=0 and done=0.
- Reset (reset_n=0, asynchronous): state=IDLE, count=0, done=0. Hence busy=0 and last=0.
- Per-edge priority: clear > start (IDLE only) > stall > normal step.
- clear=1: state=IDLE, count=0, done=0, in any state.
- IDLE: count held at 0. start=1 -> RUN with count=0; the first step index is presented the cycle after start. stall is ignored in IDLE.
- RUN, stall=1: count, state and done=0 are held.
- RUN, stall=0, count != MAX_COUNT: count increments by 1.
- RUN, stall=0, count == MAX_COUNT (terminal step): done=1 on the next cycle.
  - WRAP=0: state -> IDLE, count -> 0.
  - WRAP=1: count -> 0, state stays RUN.
- start while in RUN is ignored.
- done is high for exactly one cycle per terminal step. A sequence of N=MAX_COUNT+1 steps with no stalls gives done exactly N+1 cycles after start is sampled.
- WRAP=0, start in the same cycle done is high: accepted (state is IDLE), and the back-to-back sequence begins.
- Increment uses WIDTH-bit arithmetic. Overflow cannot occur because count never exceeds MAX_COUNT.
- reset_n asserted mid-sequence aborts immediately. Outputs reach reset values without waiting for a clock edge.

Optional Feature:
- Macro MULTDIV_CNT_LOAD_EN.
- Defined: adds ports load (in, 1) and load_value (in, WIDTH). load=1 sets count=load_value and state=RUN, in any state. Priority is below clear and above start and stall.
  - load_value > MAX_COUNT: saturate to MAX_COUNT.
  - A load never generates done by itself.
- Undefined: the load and load_value ports do not exist; behaviour is exactly the base behaviour above.

Decomposition:
- Package multdiv_pkg holds:
  - State width constant MDCNT_STATE_W=2.
  - State codes MDCNT_IDLE=2'b00 and MDCNT_RUN=2'b01.
  - Function mdcnt_terminal(count, max) for reuse by the datapath.
- One sub-module: multdiv_dffr_bank, a WIDTH-parametrised bank of flip-flops with asynchronous active-low reset.
  - Used for the count register; the state and done flops are a second instance.
  - All next-state logic stays in the top module.

Test Plan:
- Reset and idle: MAX_COUNT=3, WRAP=0, reset_n low then high, no start -> count=0, busy=0, done=0 for 10 cycles.
- Normal run: MAX_COUNT=3, WRAP=0, start pulsed at cycle 0 -> count 0,1,2,3 on cycles 1-4; last=1 on cycle 4; done=1 on cycle 5 only; busy=0 on cycle 5.
- Stall: same setup, stall=1 on cycles 2-3 -> count holds 1 for 3 cycles; done on cycle 7; start at cycle 3 ignored.
- Wrap mode: WRAP=1, MAX_COUNT=3, start at cycle 0, run 12 cycles -> count sequence 0,1,2,3,0,1,...; done pulses on cycles 5 and 9; busy stays 1.
- Abort: clear at cycle 2 mid-run -> count=0, busy=0 at cycle 3, no done. Separately, reset_n low at cycle 3 mid-run -> outputs reset immediately, without a clock edge.
- With MULTDIV_CNT_LOAD_EN: load_value=2 with load in IDLE -> RUN with count 2,3, then done. load_value=7 with MAX_COUNT=3 -> count=3 (saturated).

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and helpers for the multdiv step counter.
// Optional load port pair is enabled by MULTDIV_CNT_LOAD_EN.
package multdiv_pkg;

    localparam int MDCNT_STATE_W = 2;
    localparam int MDCNT_CMP_W   = 32;

    localparam logic [MDCNT_STATE_W-1:0] MDCNT_IDLE = 2'b00;
    localparam logic [MDCNT_STATE_W-1:0] MDCNT_RUN  = 2'b01;

    function automatic logic mdcnt_terminal(
        input logic [MDCNT_CMP_W-1:0] count,
        input logic [MDCNT_CMP_W-1:0] max
    );
        return count == max;
    endfunction

endpackage

// File: rtl/multdiv_dffr_bank.sv
// WIDTH-bit flop bank, asynchronous active-low reset to zero.
// Used for the count register and the state/done register.
module multdiv_dffr_bank #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/multdiv_step_counter.sv
// Step counter for the multdiv sequencer: IDLE/RUN, stall, clear, wrap.
// Define MULTDIV_CNT_LOAD_EN to add the load/load_value ports.
module multdiv_step_counter
    import multdiv_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int MAX_COUNT = 31,
    parameter int WRAP      = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             start,
    input  logic             stall,
`ifdef MULTDIV_CNT_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done
);

    if (WIDTH < 1) begin : g_bad_width
        $error("multdiv_step_counter: WIDTH must be >= 1");
    end

    if (MAX_COUNT < 1 ||
        longint'(MAX_COUNT) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("multdiv_step_counter: MAX_COUNT out of range");
    end

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic [MDCNT_STATE_W-1:0] r_state;
    logic [MDCNT_STATE_W-1:0] w_state_nxt;
    logic                     r_done;
    logic                     w_done_nxt;
    logic [WIDTH-1:0]         r_count;
    logic [WIDTH-1:0]         w_count_nxt;
    logic                     w_term;

    assign w_term = mdcnt_terminal(MDCNT_CMP_W'(r_count),
                                   MDCNT_CMP_W'(MAX_COUNT));

`ifdef MULTDIV_CNT_LOAD_EN
    logic [WIDTH-1:0] w_load_val;

    assign w_load_val = (load_value > MAX_C) ? MAX_C : load_value;
`endif

    multdiv_dffr_bank #(
        .WIDTH (WIDTH)
    ) u_count_q (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     (w_count_nxt),
        .o_q     (r_count)
    );

    multdiv_dffr_bank #(
        .WIDTH (MDCNT_STATE_W + 1)
    ) u_ctrl_q (
        .i_clk   (clock),
        .i_rst_n (reset_n),
        .i_d     ({w_state_nxt, w_done_nxt}),
        .o_q     ({r_state, r_done})
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = MDCNT_IDLE;
            w_count_nxt = '0;
`ifdef MULTDIV_CNT_LOAD_EN
        end else if (load) begin
            w_state_nxt = MDCNT_RUN;
            w_count_nxt = w_load_val;
`endif
        end else begin
            unique case (r_state)
                MDCNT_IDLE: begin
                    w_count_nxt = '0;
                    if (start) begin
                        w_state_nxt = MDCNT_RUN;
                    end
                end
                MDCNT_RUN: begin
                    if (!stall) begin
                        if (w_term) begin
                            w_done_nxt  = 1'b1;
                            w_count_nxt = '0;
                            w_state_nxt = (WRAP != 0) ? MDCNT_RUN
                                                      : MDCNT_IDLE;
                        end else begin
                            w_count_nxt = r_count + WIDTH'(1);
                        end
                    end
                end
                // codes 2 and 3 are unreachable; fall back to IDLE
                default: begin
                    w_state_nxt = MDCNT_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        count = r_count;
        busy  = (r_state == MDCNT_RUN);
        last  = (r_state == MDCNT_RUN) && w_term;
        done  = r_done;
    end

endmodule

// File: tb/tb_multdiv_step_counter.sv
// Bench for multdiv_step_counter: WRAP=0 and WRAP=1 instances,
// MAX_COUNT=3, WIDTH=3; load rows run when MULTDIV_CNT_LOAD_EN is set.
module tb_multdiv_step_counter;

    localparam int W = 3;

    logic         clock;
    logic         reset_n;
    logic         clr0, start0, stall0;
    logic         clr1, start1, stall1;
    logic         load0, load1;
    logic [W-1:0] lv0, lv1;
    logic [W-1:0] cnt0, cnt1;
    logic         busy0, last0, done0;
    logic         busy1, last1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit       sel;
        bit       clr;
        bit       st;
        bit       stl;
        bit       ld;
        logic [W-1:0] lv;
        logic [W-1:0] cnt;
        bit       busy;
        bit       last;
        bit       done;
    } vec_t;

    typedef struct {
        int           row;
        bit           sel;
        logic [W-1:0] cnt;
        bit           busy;
        bit           last;
        bit           done;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    multdiv_step_counter #(
        .WIDTH     (W),
        .MAX_COUNT (3),
        .WRAP      (0)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clr0),
        .start      (start0),
        .stall      (stall0),
`ifdef MULTDIV_CNT_LOAD_EN
        .load       (load0),
        .load_value (lv0),
`endif
        .count      (cnt0),
        .busy       (busy0),
        .last       (last0),
        .done       (done0)
    );

    multdiv_step_counter #(
        .WIDTH     (W),
        .MAX_COUNT (3),
        .WRAP      (1)
    ) u_wrap (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clr1),
        .start      (start1),
        .stall      (stall1),
`ifdef MULTDIV_CNT_LOAD_EN
        .load       (load1),
        .load_value (lv1),
`endif
        .count      (cnt1),
        .busy       (busy1),
        .last       (last1),
        .done       (done1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic vec_t v(bit sel, bit clr, bit st, bit stl,
                               bit ld, int lv, int cnt,
                               bit b, bit l, bit d);
        vec_t r;
        r.sel  = sel;
        r.clr  = clr;
        r.st   = st;
        r.stl  = stl;
        r.ld   = ld;
        r.lv   = W'(lv);
        r.cnt  = W'(cnt);
        r.busy = b;
        r.last = l;
        r.done = d;
        return r;
    endfunction

    task automatic drive_idle();
        clr0 = 1'b0; start0 = 1'b0; stall0 = 1'b0;
        clr1 = 1'b0; start1 = 1'b0; stall1 = 1'b0;
        load0 = 1'b0; load1 = 1'b0;
        lv0 = '0; lv1 = '0;
    endtask

    task automatic drive(input vec_t x);
        drive_idle();
        if (x.sel) begin
            clr1 = x.clr; start1 = x.st; stall1 = x.stl;
            load1 = x.ld; lv1 = x.lv;
        end else begin
            clr0 = x.clr; start0 = x.st; stall0 = x.stl;
            load0 = x.ld; lv0 = x.lv;
        end
    endtask

    task automatic check_pending(input string name);
        exp_t         e;
        logic [W-1:0] gc;
        bit           gb, gl, gd;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.sel) begin
                gc = cnt1; gb = busy1; gl = last1; gd = done1;
            end else begin
                gc = cnt0; gb = busy0; gl = last0; gd = done0;
            end
            n_checks++;
            if (gc !== e.cnt || gb !== e.busy ||
                gl !== e.last || gd !== e.done) begin
                n_fail++;
                $display("FAIL %s row %0d: got cnt=%0d busy=%0b last=%0b done=%0b, want cnt=%0d busy=%0b last=%0b done=%0b",
                         name, e.row, gc, gb, gl, gd,
                         e.cnt, e.busy, e.last, e.done);
            end
        end
    endtask

    task automatic run_vecs(input string name);
        exp_t e;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            check_pending(name);
            drive(vecs[i]);
            e.row  = i;
            e.sel  = vecs[i].sel;
            e.cnt  = vecs[i].cnt;
            e.busy = vecs[i].busy;
            e.last = vecs[i].last;
            e.done = vecs[i].done;
            sb.push_back(e);
        end
        @(negedge clock);
        check_pending(name);
        drive_idle();
        vecs.delete();
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic quiesce();
        @(negedge clock);
        drive_idle();
        clr0 = 1'b1;
        clr1 = 1'b1;
        @(negedge clock);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // reset and idle, no start
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("reset_idle0", int'({cnt0, busy0, last0, done0}), 0);
            chk("reset_idle1", int'({cnt1, busy1, last1, done1}), 0);
        end

        // normal run
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("normal");
        quiesce();

        // stall cycles 2-3, start at cycle 3 ignored
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 1, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("stall");
        quiesce();

        // stall on the terminal step delays done
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("stall_term");
        quiesce();

        // back-to-back: start while done is high
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        run_vecs("back2back");
        quiesce();

        // clear mid-run, clear on terminal step, clear beats start
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("clear");
        quiesce();

        // wrap mode
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 1, 1, 0, 0));
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 2, 1, 0, 0));
            vecs.push_back(v(1, 0, 0, 0, 0, 0, 3, 1, 1, 0));
            if (k < 2) begin
                vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
            end
        end
        vecs.push_back(v(1, 0, 0, 1, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        vecs.push_back(v(1, 0, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("wrap");
        quiesce();

`ifdef MULTDIV_CNT_LOAD_EN
        // load in IDLE, saturating load, load in RUN, clear beats load
        vecs.push_back(v(0, 0, 0, 0, 1, 2, 2, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 7, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0, 3, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 1, 2, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_vecs("load");
        quiesce();
`endif

        // asynchronous reset mid-run
        @(negedge clock);
        start0 = 1'b1;
        @(negedge clock);
        start0 = 1'b0;
        repeat (2) @(negedge clock);
        chk("pre_reset_cnt", int'(cnt0), 2);
        chk("pre_reset_busy", int'(busy0), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset0", int'({cnt0, busy0, last0, done0}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset0", int'({cnt0, busy0, last0, done0}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
